// File: rtl/banco_barramento.sv
// banco_barramento: general register bank whose top register doubles as the PC,
// plus a single-entry valid/ready output stage that drives the datapath bus
// from a bank register, the instruction register, or an extended immediate.
module banco_barramento #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  parameter  int IMM_W = 10,
  localparam int SW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             inc_en,
  input  logic             rd_req,
  output logic             rd_ready,
  input  logic [1:0]       src_mode,
  input  logic [SW-1:0]    rd_sel,
  input  logic [WIDTH-1:0] iR,
  input  logic [IMM_W-1:0] imediato,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SW-1:0] PC_IDX = SW'(NREGS - 1);

  localparam logic [1:0] SRC_BANK = 2'b00;
  localparam logic [1:0] SRC_IR   = 2'b01;
  localparam logic [1:0] SRC_ZEXT = 2'b10;
  localparam logic [1:0] SRC_SEXT = 2'b11;

  logic [WIDTH-1:0] regs      [NREGS];
  logic [WIDTH-1:0] regs_next [NREGS];
  logic [WIDTH-1:0] src_value;
  logic             accept;
  logic             consume;

  assign rd_ready = !out_valid || out_ready;
  assign accept   = rd_req && rd_ready;
  assign consume  = out_valid && out_ready;

  // Post-update bank contents; the explicit write is applied last so it
  // overrides a concurrent PC increment.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_next[i] = regs[i];
    end
    if (inc_en) begin
      regs_next[PC_IDX] = regs[PC_IDX] + WIDTH'(1);
    end
    if (wr_en) begin
      regs_next[wr_sel] = din;
    end
  end

  // Bus source mux; bank reads come from the post-update view so a same-cycle
  // write or increment is captured without an extra cycle of latency.
  always_comb begin
    src_value = '0;
    case (src_mode)
      SRC_BANK: src_value = regs_next[rd_sel];
      SRC_IR:   src_value = iR;
      SRC_ZEXT: src_value = WIDTH'(imediato);
      SRC_SEXT: src_value = WIDTH'($signed(imediato));
      default:  src_value = '0;
    endcase
  end

  // Register bank storage; updates are independent of the output handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= regs_next[i];
      end
    end
  end

  // Output stage: load on accept, otherwise drop valid once consumed while
  // holding the last value on the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= src_value;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banco_barramento.sv
// Bench for banco_barramento: a table of single-cycle vectors followed by
// hand-written stall, streaming and mid-transfer reset sequences.
module tb_banco_barramento;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] din;
  logic        inc_en;
  logic        rd_req;
  logic        rd_ready;
  logic [1:0]  src_mode;
  logic [2:0]  rd_sel;
  logic [15:0] iR;
  logic [9:0]  imediato;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  banco_barramento #(.WIDTH(16), .NREGS(8), .IMM_W(10)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .din(din),
    .inc_en(inc_en), .rd_req(rd_req), .rd_ready(rd_ready), .src_mode(src_mode),
    .rd_sel(rd_sel), .iR(iR), .imediato(imediato), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] din;
    logic        inc_en;
    logic        rd_req;
    logic [1:0]  src_mode;
    logic [2:0]  rd_sel;
    logic [15:0] ir;
    logic [9:0]  imm;
    logic        out_ready;
    logic [15:0] exp_out;
    logic        exp_valid;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_sel = 3'd0; din = 16'h0; inc_en = 1'b0;
    rd_req = 1'b0; src_mode = 2'b00; rd_sel = 3'd0; iR = 16'h0;
    imediato = 10'h0; out_ready = 1'b0;
  endtask

  // Applies the current inputs across one rising edge and returns at the next
  // falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // wr_en wr_sel din inc rd_req mode rd_sel iR imm out_ready | out valid ready
    vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 1'b1, 2'b00, 3'd3, 16'h0000, 10'h000, 1'b0, 16'h1234, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 10'h000, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b10, 3'd0, 16'h0000, 10'h3F0, 1'b1, 16'h03F0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b11, 3'd0, 16'h0000, 10'h3F0, 1'b1, 16'hFFF0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b01, 3'd0, 16'hBEEF, 10'h3F0, 1'b1, 16'hBEEF, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b1, 2'b00, 3'd7, 16'h0000, 10'h000, 1'b1, 16'hFFFF, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'b00, 3'd7, 16'h0000, 10'h000, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 3'd7, 16'h0040, 1'b1, 1'b1, 2'b00, 3'd7, 16'h0000, 10'h000, 1'b1, 16'h0040, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b00, 3'd7, 16'h0000, 10'h000, 1'b1, 16'h0040, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'b00, 3'd7, 16'h0000, 10'h000, 1'b1, 16'h0041, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b11, 3'd0, 16'h0000, 10'h1FF, 1'b1, 16'h01FF, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b11, 3'd0, 16'h0000, 10'h200, 1'b1, 16'hFE00, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'b00, 3'd3, 16'h0000, 10'h000, 1'b1, 16'h1234, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 10'h000, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 3'd0, 16'h0001, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 10'h000, 1'b0, 16'h1234, 1'b0, 1'b1};

    idle_inputs();
    reset = 1'b1;
    #12;
    check("reset_out", out, 16'h0000);
    check("reset_valid", 16'(out_valid), 16'h0000);
    check("reset_ready", 16'(rd_ready), 16'h0001);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      wr_en = vecs[i].wr_en;   wr_sel = vecs[i].wr_sel;     din = vecs[i].din;
      inc_en = vecs[i].inc_en; rd_req = vecs[i].rd_req;     src_mode = vecs[i].src_mode;
      rd_sel = vecs[i].rd_sel; iR = vecs[i].ir;             imediato = vecs[i].imm;
      out_ready = vecs[i].out_ready;
      step();
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ready", i), 16'(rd_ready), 16'(vecs[i].exp_ready));
    end

    // Stall: hold 0x0011 while the consumer is not ready, then release.
    idle_inputs();
    rd_req = 1'b1; src_mode = 2'b10; imediato = 10'h011; out_ready = 1'b0;
    step();
    check("stall_first_out", out, 16'h0011);
    imediato = 10'h022;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_ready", c), 16'(rd_ready), 16'h0000);
      check($sformatf("stall%0d_out", c), out, 16'h0011);
      check($sformatf("stall%0d_valid", c), 16'(out_valid), 16'h0001);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", 16'(rd_ready), 16'h0001);
    step();
    check("stall_release_out", out, 16'h0022);
    check("stall_release_valid", 16'(out_valid), 16'h0001);
    rd_req = 1'b0;
    step();
    check("stall_drain_valid", 16'(out_valid), 16'h0000);
    check("stall_drain_out", out, 16'h0022);

    // Streaming: preload r0..r3 with 1..4, then read them back-to-back.
    idle_inputs();
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wr_en = 1'b1; wr_sel = 3'(r); din = 16'(r + 1);
      step();
    end
    wr_en = 1'b0;
    rd_req = 1'b1; src_mode = 2'b00;
    for (int r = 0; r < 4; r++) begin
      rd_sel = 3'(r);
      step();
      check($sformatf("stream%0d_out", r), out, 16'(r + 1));
      check($sformatf("stream%0d_valid", r), 16'(out_valid), 16'h0001);
    end
    rd_req = 1'b0;
    step();
    check("stream_end_valid", 16'(out_valid), 16'h0000);

    // Asynchronous reset while a value sits stalled in the output stage.
    idle_inputs();
    wr_en = 1'b1; wr_sel = 3'd5; din = 16'h5555;
    rd_req = 1'b1; src_mode = 2'b00; rd_sel = 3'd5; out_ready = 1'b0;
    step();
    check("prereset_out", out, 16'h5555);
    check("prereset_valid", 16'(out_valid), 16'h0001);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", 16'(out_valid), 16'h0000);
    check("async_reset_out", out, 16'h0000);
    check("async_reset_ready", 16'(rd_ready), 16'h0001);
    @(negedge clock);
    reset = 1'b0;
    rd_req = 1'b1; src_mode = 2'b00; rd_sel = 3'd5; out_ready = 1'b1;
    step();
    check("postreset_r5_out", out, 16'h0000);
    check("postreset_valid", 16'(out_valid), 16'h0001);
    rd_sel = 3'd7;
    step();
    check("postreset_pc_out", out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
